// File: rtl/decoder_riscv_pkg.sv
// Opcode map, ALU operation codes and immediate extraction shared by the RV32I decoder, ALU and core.
package decoder_riscv_pkg;
  localparam logic [4:0] OPC_LOAD     = 5'b00000;
  localparam logic [4:0] OPC_MISC_MEM = 5'b00011;
  localparam logic [4:0] OPC_OP_IMM   = 5'b00100;
  localparam logic [4:0] OPC_AUIPC    = 5'b00101;
  localparam logic [4:0] OPC_STORE    = 5'b01000;
  localparam logic [4:0] OPC_OP       = 5'b01100;
  localparam logic [4:0] OPC_LUI      = 5'b01101;
  localparam logic [4:0] OPC_BRANCH   = 5'b11000;
  localparam logic [4:0] OPC_JALR     = 5'b11001;
  localparam logic [4:0] OPC_JAL      = 5'b11011;
  localparam logic [4:0] OPC_SYSTEM   = 5'b11100;

  // Low 3 bits follow funct3 so the decoder can concatenate them directly.
  localparam logic [4:0] ALU_ADD  = 5'b00000;
  localparam logic [4:0] ALU_SLL  = 5'b00001;
  localparam logic [4:0] ALU_SLTS = 5'b00010;
  localparam logic [4:0] ALU_SLTU = 5'b00011;
  localparam logic [4:0] ALU_XOR  = 5'b00100;
  localparam logic [4:0] ALU_SRL  = 5'b00101;
  localparam logic [4:0] ALU_OR   = 5'b00110;
  localparam logic [4:0] ALU_AND  = 5'b00111;
  localparam logic [4:0] ALU_SUB  = 5'b01000;
  localparam logic [4:0] ALU_SRA  = 5'b01101;
  localparam logic [4:0] ALU_EQ   = 5'b11000;
  localparam logic [4:0] ALU_NE   = 5'b11001;
  localparam logic [4:0] ALU_LTS  = 5'b11100;
  localparam logic [4:0] ALU_GES  = 5'b11101;
  localparam logic [4:0] ALU_LTU  = 5'b11110;
  localparam logic [4:0] ALU_GEU  = 5'b11111;

  localparam logic WB_EX  = 1'b0;
  localparam logic WB_LSU = 1'b1;

  function automatic logic [31:0] imm_i(input logic [31:0] i);
    return {{20{i[31]}}, i[31:20]};
  endfunction
  function automatic logic [31:0] imm_s(input logic [31:0] i);
    return {{20{i[31]}}, i[31:25], i[11:7]};
  endfunction
  function automatic logic [31:0] imm_b(input logic [31:0] i);
    return {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
  endfunction
  function automatic logic [31:0] imm_u(input logic [31:0] i);
    return {i[31:12], 12'b0};
  endfunction
  function automatic logic [31:0] imm_j(input logic [31:0] i);
    return {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
  endfunction
endpackage

// File: rtl/riscv_core_mc_pkg.sv
// Multi-cycle core state encoding, operand-select encodings and the reset IR value.
package riscv_core_mc_pkg;
  typedef enum logic [1:0] {
    ST_FETCH  = 2'd0,
    ST_WAIT_I = 2'd1,
    ST_EXEC   = 2'd2,
    ST_MEM    = 2'd3
  } state_e;

  localparam logic [1:0] OP_A_RS1    = 2'd0;
  localparam logic [1:0] OP_A_CURR_PC = 2'd1;
  localparam logic [1:0] OP_A_ZERO   = 2'd2;

  localparam logic [2:0] OP_B_RS2    = 3'd0;
  localparam logic [2:0] OP_B_IMM_I  = 3'd1;
  localparam logic [2:0] OP_B_IMM_U  = 3'd2;
  localparam logic [2:0] OP_B_IMM_S  = 3'd3;
  localparam logic [2:0] OP_B_INCR   = 3'd4;

  localparam logic [31:0] NOP = 32'h0000_0013;
endpackage

// File: rtl/alu_riscv.sv
// RV32I ALU: arithmetic/logic result plus a separate comparison flag for branches.
module alu_riscv
  import decoder_riscv_pkg::*;
(
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  input  logic [4:0]  alu_op_i,
  output logic        flag_o,
  output logic [31:0] result_o
);
  always_comb begin
    result_o = 32'd0;
    flag_o   = 1'b0;
    case (alu_op_i)
      ALU_ADD:  result_o = a_i + b_i;
      ALU_SUB:  result_o = a_i - b_i;
      ALU_XOR:  result_o = a_i ^ b_i;
      ALU_OR:   result_o = a_i | b_i;
      ALU_AND:  result_o = a_i & b_i;
      ALU_SLL:  result_o = a_i << b_i[4:0];
      ALU_SRL:  result_o = a_i >> b_i[4:0];
      ALU_SRA:  result_o = $signed(a_i) >>> b_i[4:0];
      ALU_SLTS: result_o = {31'd0, $signed(a_i) < $signed(b_i)};
      ALU_SLTU: result_o = {31'd0, a_i < b_i};
      ALU_EQ:   flag_o = (a_i == b_i);
      ALU_NE:   flag_o = (a_i != b_i);
      ALU_LTS:  flag_o = $signed(a_i) <  $signed(b_i);
      ALU_GES:  flag_o = $signed(a_i) >= $signed(b_i);
      ALU_LTU:  flag_o = a_i <  b_i;
      ALU_GEU:  flag_o = a_i >= b_i;
      default: ;
    endcase
  end
endmodule

// File: rtl/decoder_riscv.sv
// RV32I main decoder: operand selects, ALU op, memory and writeback controls, illegal detect.
module decoder_riscv
  import decoder_riscv_pkg::*;
  import riscv_core_mc_pkg::*;
(
  input  logic [31:0] fetched_instr_i,
  output logic [1:0]  a_sel_o,
  output logic [2:0]  b_sel_o,
  output logic [4:0]  alu_op_o,
  output logic [2:0]  mem_size_o,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic        gpr_we_o,
  output logic        wb_sel_o,
  output logic        illegal_instr_o,
  output logic        branch_o,
  output logic        jal_o,
  output logic        jalr_o
);
  logic [4:0] opc;
  logic [2:0] f3;
  logic [6:0] f7;
  logic       unused_fields;

  assign opc = fetched_instr_i[6:2];
  assign f3  = fetched_instr_i[14:12];
  assign f7  = fetched_instr_i[31:25];
  assign unused_fields = ^{fetched_instr_i[24:15], fetched_instr_i[11:7]};

  always_comb begin
    a_sel_o = OP_A_RS1;
    b_sel_o = OP_B_RS2;
    alu_op_o = ALU_ADD;
    mem_size_o = f3;
    mem_req_o = 1'b0;
    mem_we_o = 1'b0;
    gpr_we_o = 1'b0;
    wb_sel_o = WB_EX;
    illegal_instr_o = 1'b0;
    branch_o = 1'b0;
    jal_o = 1'b0;
    jalr_o = 1'b0;
    if (fetched_instr_i[1:0] != 2'b11) illegal_instr_o = 1'b1;
    else begin
      case (opc)
        OPC_OP: begin
          gpr_we_o = 1'b1;
          if (f7 == 7'h00) alu_op_o = {2'b00, f3};
          else if (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5)) alu_op_o = {2'b01, f3};
          else illegal_instr_o = 1'b1;
        end
        OPC_OP_IMM: begin
          gpr_we_o = 1'b1;
          b_sel_o = OP_B_IMM_I;
          alu_op_o = {2'b00, f3};
          if (f3 == 3'd1 && f7 != 7'h00) illegal_instr_o = 1'b1;
          if (f3 == 3'd5) begin
            if (f7 == 7'h20) alu_op_o = ALU_SRA;
            else if (f7 != 7'h00) illegal_instr_o = 1'b1;
          end
        end
        OPC_LUI: begin
          gpr_we_o = 1'b1;
          a_sel_o = OP_A_ZERO;
          b_sel_o = OP_B_IMM_U;
        end
        OPC_AUIPC: begin
          gpr_we_o = 1'b1;
          a_sel_o = OP_A_CURR_PC;
          b_sel_o = OP_B_IMM_U;
        end
        OPC_LOAD: begin
          gpr_we_o = 1'b1;
          mem_req_o = 1'b1;
          wb_sel_o = WB_LSU;
          b_sel_o = OP_B_IMM_I;
          if (f3 == 3'd3 || f3 > 3'd5) illegal_instr_o = 1'b1;
        end
        OPC_STORE: begin
          mem_req_o = 1'b1;
          mem_we_o = 1'b1;
          b_sel_o = OP_B_IMM_S;
          if (f3 > 3'd2) illegal_instr_o = 1'b1;
        end
        OPC_BRANCH: begin
          branch_o = 1'b1;
          alu_op_o = {2'b11, f3};
          if (f3 == 3'd2 || f3 == 3'd3) illegal_instr_o = 1'b1;
        end
        OPC_JAL: begin
          jal_o = 1'b1;
          gpr_we_o = 1'b1;
          a_sel_o = OP_A_CURR_PC;
          b_sel_o = OP_B_INCR;
        end
        OPC_JALR: begin
          jalr_o = 1'b1;
          gpr_we_o = 1'b1;
          a_sel_o = OP_A_CURR_PC;
          b_sel_o = OP_B_INCR;
          if (f3 != 3'd0) illegal_instr_o = 1'b1;
        end
        // FENCE / ECALL / EBREAK retire as no-ops
        OPC_MISC_MEM, OPC_SYSTEM: if (f3 != 3'd0) illegal_instr_o = 1'b1;
        default: illegal_instr_o = 1'b1;
      endcase
    end
    if (illegal_instr_o) begin
      gpr_we_o = 1'b0;
      mem_req_o = 1'b0;
      mem_we_o = 1'b0;
      branch_o = 1'b0;
      jal_o = 1'b0;
      jalr_o = 1'b0;
    end
  end
endmodule

// File: rtl/rf_riscv.sv
// 31x32 register file, two async read ports, one sync write port; x0 has no storage.
module rf_riscv (
  input  logic        clk_i,
  input  logic [4:0]  raddr1_i,
  input  logic [4:0]  raddr2_i,
  input  logic [4:0]  waddr_i,
  input  logic [31:0] wdata_i,
  input  logic        we_i,
  output logic [31:0] rdata1_o,
  output logic [31:0] rdata2_o
);
  logic [31:0] rf_mem [1:31];

  always_ff @(posedge clk_i)
    if (we_i && waddr_i != 5'd0) rf_mem[waddr_i] <= wdata_i;

  assign rdata1_o = (raddr1_i == 5'd0) ? 32'd0 : rf_mem[raddr1_i];
  assign rdata2_o = (raddr2_i == 5'd0) ? 32'd0 : rf_mem[raddr2_i];
endmodule

// File: rtl/riscv_next_pc.sv
// Combinational next-PC: trap vector, JALR target, JAL/branch offsets, or sequential.
module riscv_next_pc #(
  parameter logic [31:0] TRAP_ADDR = 32'h0000_0100
) (
  input  logic [31:0] pc_i,
  input  logic [31:0] rs1_i,
  input  logic [31:0] imm_i_i,
  input  logic [31:0] imm_j_i,
  input  logic [31:0] imm_b_i,
  input  logic        illegal_i,
  input  logic        jal_i,
  input  logic        jalr_i,
  input  logic        branch_i,
  input  logic        flag_i,
  output logic [31:0] next_pc_o
);
  logic [31:0] jalr_tgt;

  assign jalr_tgt = rs1_i + imm_i_i;

  always_comb begin
    next_pc_o = pc_i + 32'd4;
    if (illegal_i)               next_pc_o = TRAP_ADDR;
    else if (jalr_i)             next_pc_o = {jalr_tgt[31:1], 1'b0};
    else if (jal_i)              next_pc_o = pc_i + imm_j_i;
    else if (branch_i && flag_i) next_pc_o = pc_i + imm_b_i;
  end
endmodule

// File: rtl/riscv_core_mc.sv
// Multi-cycle RV32I core: FETCH -> WAIT_I -> EXEC [-> MEM] with handshaked instruction/data memories.
module riscv_core_mc
  import riscv_core_mc_pkg::*;
  import decoder_riscv_pkg::*;
#(
  parameter logic [31:0] RESET_ADDR = 32'h0000_0000,
  parameter logic [31:0] TRAP_ADDR  = 32'h0000_0100,
  parameter int          CNT_W      = 32
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  output logic             imem_req_o,
  output logic [31:0]      imem_addr_o,
  input  logic             imem_rvalid_i,
  input  logic [31:0]      imem_rdata_i,
  output logic             dmem_req_o,
  output logic             dmem_we_o,
  output logic [2:0]       dmem_size_o,
  output logic [31:0]      dmem_addr_o,
  output logic [31:0]      dmem_wdata_o,
  input  logic             dmem_ready_i,
  input  logic [31:0]      dmem_rdata_i,
  output logic             illegal_o,
  output logic [CNT_W-1:0] instret_o
);
  state_e           state_q, state_d;
  logic [31:0]      pc_q, pc_d, ir_q, ir_d;
  logic [CNT_W-1:0] instret_q, instret_d;

  logic [1:0]  a_sel;
  logic [2:0]  b_sel, mem_size;
  logic [4:0]  alu_op;
  logic        mem_req, mem_we, gpr_we, wb_sel, illegal, branch, jal, jalr;
  logic        alu_flag, rf_we;
  logic [31:0] rs1, rs2, op_a, op_b, alu_res, rf_wdata, next_pc;

  decoder_riscv u_dec (
    .fetched_instr_i (ir_q),
    .a_sel_o         (a_sel),
    .b_sel_o         (b_sel),
    .alu_op_o        (alu_op),
    .mem_size_o      (mem_size),
    .mem_req_o       (mem_req),
    .mem_we_o        (mem_we),
    .gpr_we_o        (gpr_we),
    .wb_sel_o        (wb_sel),
    .illegal_instr_o (illegal),
    .branch_o        (branch),
    .jal_o           (jal),
    .jalr_o          (jalr)
  );

  rf_riscv u_rf (
    .clk_i    (clk_i),
    .raddr1_i (ir_q[19:15]),
    .raddr2_i (ir_q[24:20]),
    .waddr_i  (ir_q[11:7]),
    .wdata_i  (rf_wdata),
    .we_i     (rf_we),
    .rdata1_o (rs1),
    .rdata2_o (rs2)
  );

  always_comb begin
    case (a_sel)
      OP_A_RS1:     op_a = rs1;
      OP_A_CURR_PC: op_a = pc_q;
      default:      op_a = 32'd0;
    endcase
    case (b_sel)
      OP_B_RS2:   op_b = rs2;
      OP_B_IMM_I: op_b = imm_i(ir_q);
      OP_B_IMM_U: op_b = imm_u(ir_q);
      OP_B_IMM_S: op_b = imm_s(ir_q);
      default:    op_b = 32'd4;
    endcase
  end

  alu_riscv u_alu (
    .a_i      (op_a),
    .b_i      (op_b),
    .alu_op_i (alu_op),
    .flag_o   (alu_flag),
    .result_o (alu_res)
  );

  riscv_next_pc #(.TRAP_ADDR(TRAP_ADDR)) u_npc (
    .pc_i      (pc_q),
    .rs1_i     (rs1),
    .imm_i_i   (imm_i(ir_q)),
    .imm_j_i   (imm_j(ir_q)),
    .imm_b_i   (imm_b(ir_q)),
    .illegal_i (illegal),
    .jal_i     (jal),
    .jalr_i    (jalr),
    .branch_i  (branch),
    .flag_i    (alu_flag),
    .next_pc_o (next_pc)
  );

  assign rf_wdata = (wb_sel == WB_LSU) ? dmem_rdata_i : alu_res;

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    ir_d       = ir_q;
    instret_d  = instret_q;
    imem_req_o = 1'b0;
    dmem_req_o = 1'b0;
    illegal_o  = 1'b0;
    rf_we      = 1'b0;
    unique case (state_q)
      ST_FETCH: begin
        imem_req_o = rst_ni; // FETCH is also the reset state; no request while held in reset
        state_d    = ST_WAIT_I;
      end
      ST_WAIT_I: if (imem_rvalid_i) begin
        ir_d    = imem_rdata_i;
        state_d = ST_EXEC;
      end
      ST_EXEC: begin
        if (illegal) begin
          illegal_o = 1'b1;
          pc_d      = next_pc;
          state_d   = ST_FETCH;
        end else if (mem_req) begin
          state_d = ST_MEM;
        end else begin
          rf_we     = gpr_we;
          pc_d      = next_pc;
          instret_d = instret_q + CNT_W'(1);
          state_d   = ST_FETCH;
        end
      end
      ST_MEM: begin
        dmem_req_o = 1'b1;
        if (dmem_ready_i) begin
          rf_we     = gpr_we;
          pc_d      = next_pc;
          instret_d = instret_q + CNT_W'(1);
          state_d   = ST_FETCH;
        end
      end
      default: state_d = ST_FETCH;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) begin
      state_q   <= ST_FETCH;
      pc_q      <= RESET_ADDR;
      ir_q      <= NOP;
      instret_q <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      ir_q      <= ir_d;
      instret_q <= instret_d;
    end

  // IR and rs values are frozen during MEM, so these stay stable until ready
  assign imem_addr_o  = pc_q;
  assign dmem_we_o    = (state_q == ST_MEM) && mem_we;
  assign dmem_size_o  = mem_size;
  assign dmem_addr_o  = alu_res;
  assign dmem_wdata_o = rs2;
  assign instret_o    = instret_q;
endmodule

// File: tb/tb_riscv_core_mc.sv
// Directed bench for riscv_core_mc: a table of single-instruction steps plus reset sequences.
module tb_riscv_core_mc;
  logic        clk = 1'b0;
  logic        rst_ni = 1'b0;
  logic        imem_req_o, imem_rvalid = 1'b0;
  logic [31:0] imem_addr_o, imem_rdata = 32'd0;
  logic        dmem_req_o, dmem_we_o, dmem_ready = 1'b0, illegal_o;
  logic [2:0]  dmem_size_o;
  logic [31:0] dmem_addr_o, dmem_wdata_o, dmem_rdata = 32'd0;
  logic [31:0] instret_o;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  riscv_core_mc #(.RESET_ADDR(32'h80), .TRAP_ADDR(32'h100), .CNT_W(32)) dut (
    .clk_i(clk), .rst_ni(rst_ni),
    .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o),
    .imem_rvalid_i(imem_rvalid), .imem_rdata_i(imem_rdata),
    .dmem_req_o(dmem_req_o), .dmem_we_o(dmem_we_o), .dmem_size_o(dmem_size_o),
    .dmem_addr_o(dmem_addr_o), .dmem_wdata_o(dmem_wdata_o),
    .dmem_ready_i(dmem_ready), .dmem_rdata_i(dmem_rdata),
    .illegal_o(illegal_o), .instret_o(instret_o)
  );

  typedef struct {
    logic [31:0] instr;
    int          iw;     // extra WAIT_I cycles before rvalid
    int          dw;     // dmem wait cycles before ready
    logic [31:0] drd;
    logic [31:0] nxt;
    int          cpi;
    int          ill;
    int          dreq;
    logic [31:0] daddr;
    logic        dwe;
    logic [31:0] wdata;
    logic [2:0]  dsize;
    int          rd;
    logic [31:0] rdv;
    logic [31:0] iret;
  } vec_t;

  vec_t v[17];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, want %h", nm, act, exp);
    end
  endtask

  // Entered at a negedge inside the fetch-request cycle; leaves at the negedge of the next request.
  task automatic step(input logic [31:0] instr, input int iw, input int dw, input logic [31:0] drd,
                      output logic [31:0] nxt, output int cpi, output int ill, output int dreq,
                      output logic [31:0] daddr, output logic dwe, output logic [31:0] wdata,
                      output logic [2:0] dsize, output int dstable);
    bit done = 1'b0;
    cpi = 1; ill = 0; dreq = 0; daddr = '0; dwe = 1'b0; wdata = '0; dsize = '0; dstable = 1;
    nxt = 32'hFFFF_FFFF;
    @(negedge clk); cpi++;
    repeat (iw) begin @(negedge clk); cpi++; end
    imem_rvalid = 1'b1; imem_rdata = instr;
    for (int k = 0; k < 40 && !done; k++) begin
      @(negedge clk);
      imem_rvalid = 1'b0; dmem_ready = 1'b0;
      if (illegal_o) ill++;
      if (imem_req_o) begin
        nxt = imem_addr_o; done = 1'b1;
      end else begin
        cpi++;
        if (dmem_req_o) begin
          dreq++;
          if (dreq == 1) begin
            daddr = dmem_addr_o; dwe = dmem_we_o; wdata = dmem_wdata_o; dsize = dmem_size_o;
          end else if (dmem_addr_o !== daddr || dmem_we_o !== dwe || dmem_wdata_o !== wdata) dstable = 0;
          if (dreq == dw + 1) begin dmem_ready = 1'b1; dmem_rdata = drd; end
        end
      end
    end
  endtask

  initial begin
    logic [31:0] nxt, daddr, wdata;
    int cpi, ill, dreq, dst;
    logic dwe;
    logic [2:0] dsize;

    //       instr          iw dw drd            nxt       cpi ill dreq daddr     dwe   wdata  size   rd rdv            iret
    v[0]  = '{32'h00500093, 0, 0, 32'h0,         32'h84,   3,  0,  0,  32'h0,   1'b0, 32'h0, 3'd0, 1, 32'd5,         32'd1};
    v[1]  = '{32'h0000A103, 0, 3, 32'hDEADBEEF,  32'h88,   7,  0,  4,  32'h5,   1'b0, 32'h0, 3'd2, 2, 32'hDEADBEEF,  32'd2};
    v[2]  = '{32'h00102423, 0, 0, 32'h0,         32'h8C,   4,  0,  1,  32'h8,   1'b1, 32'h5, 3'd2, 1, 32'd5,         32'd3};
    v[3]  = '{32'h002081B3, 0, 0, 32'h0,         32'h90,   3,  0,  0,  32'h0,   1'b0, 32'h0, 3'd0, 3, 32'hDEADBEF4,  32'd4};
    v[4]  = '{32'h40208233, 0, 0, 32'h0,         32'h94,   3,  0,  0,  32'h0,   1'b0, 32'h0, 3'd0, 4, 32'h21524116,  32'd5};
    v[5]  = '{32'h123452B7, 0, 0, 32'h0,         32'h98,   3,  0,  0,  32'h0,   1'b0, 32'h0, 3'd0, 5, 32'h12345000,  32'd6};
    v[6]  = '{32'h00000000, 0, 0, 32'h0,         32'h100,  3,  1,  0,  32'h0,   1'b0, 32'h0, 3'd0, 5, 32'h12345000,  32'd6};
    v[7]  = '{32'hF41FF36F, 0, 0, 32'h0,         32'h40,   3,  0,  0,  32'h0,   1'b0, 32'h0, 3'd0, 6, 32'h104,       32'd7};
    v[8]  = '{32'hFE000CE3, 0, 0, 32'h0,         32'h38,   3,  0,  0,  32'h0,   1'b0, 32'h0, 3'd0, 6, 32'h104,       32'd8};
    v[9]  = '{32'hFE001CE3, 0, 0, 32'h0,         32'h3C,   3,  0,  0,  32'h0,   1'b0, 32'h0, 3'd0, 6, 32'h104,       32'd9};
    v[10] = '{32'h10100193, 2, 0, 32'h0,         32'h40,   5,  0,  0,  32'h0,   1'b0, 32'h0, 3'd0, 3, 32'h101,       32'd10};
    v[11] = '{32'h004180E7, 0, 0, 32'h0,         32'h104,  3,  0,  0,  32'h0,   1'b0, 32'h0, 3'd0, 1, 32'h44,        32'd11};
    v[12] = '{32'h0041B3B3, 0, 0, 32'h0,         32'h108,  3,  0,  0,  32'h0,   1'b0, 32'h0, 3'd0, 7, 32'h1,         32'd12};
    v[13] = '{32'h40415413, 0, 0, 32'h0,         32'h10C,  3,  0,  0,  32'h0,   1'b0, 32'h0, 3'd0, 8, 32'hFDEADBEE,  32'd13};
    v[14] = '{32'h0001A003, 0, 0, 32'h55,        32'h110,  4,  0,  1,  32'h101, 1'b0, 32'h0, 3'd2, 8, 32'hFDEADBEE,  32'd14};
    v[15] = '{32'h00700493, 0, 0, 32'h0,         32'h114,  3,  0,  0,  32'h0,   1'b0, 32'h0, 3'd0, 9, 32'h7,         32'd15};
    v[16] = '{32'hFFFFFFFF, 0, 0, 32'h0,         32'h100,  3,  1,  0,  32'h0,   1'b0, 32'h0, 3'd0, 9, 32'h7,         32'd15};

    // Held in reset: no requests, counter cleared
    @(negedge clk);
    @(negedge clk);
    chk("rst_imem_req", 64'(imem_req_o), 64'd0);
    chk("rst_dmem_req", 64'(dmem_req_o), 64'd0);
    chk("rst_illegal",  64'(illegal_o),  64'd0);
    chk("rst_instret",  64'(instret_o),  64'd0);
    rst_ni = 1'b1;
    #1;
    chk("first_req",  64'(imem_req_o),  64'd1);
    chk("first_addr", 64'(imem_addr_o), 64'h80);

    for (int i = 0; i < 17; i++) begin
      step(v[i].instr, v[i].iw, v[i].dw, v[i].drd, nxt, cpi, ill, dreq, daddr, dwe, wdata, dsize, dst);
      chk($sformatf("v%0d_next_pc", i), 64'(nxt), 64'(v[i].nxt));
      chk($sformatf("v%0d_cpi", i),     64'(cpi), 64'(v[i].cpi));
      chk($sformatf("v%0d_illegal", i), 64'(ill), 64'(v[i].ill));
      chk($sformatf("v%0d_dreq", i),    64'(dreq), 64'(v[i].dreq));
      chk($sformatf("v%0d_instret", i), 64'(instret_o), 64'(v[i].iret));
      chk($sformatf("v%0d_x%0d", i, v[i].rd), 64'(dut.u_rf.rf_mem[v[i].rd]), 64'(v[i].rdv));
      if (v[i].dreq > 0) begin
        chk($sformatf("v%0d_daddr", i),  64'(daddr), 64'(v[i].daddr));
        chk($sformatf("v%0d_dwe", i),    64'(dwe),   64'(v[i].dwe));
        chk($sformatf("v%0d_dsize", i),  64'(dsize), 64'(v[i].dsize));
        chk($sformatf("v%0d_dstable", i), 64'(dst),  64'd1);
        if (v[i].dwe) chk($sformatf("v%0d_wdata", i), 64'(wdata), 64'(v[i].wdata));
      end
    end

    // Reset while a load is waiting in MEM (PC=0x100, x1=0x44)
    @(negedge clk);
    imem_rvalid = 1'b1; imem_rdata = 32'h0000A103;
    @(negedge clk);
    imem_rvalid = 1'b0;
    @(negedge clk);
    chk("mem_req_before_rst", 64'(dmem_req_o),  64'd1);
    chk("mem_addr_before_rst", 64'(dmem_addr_o), 64'h44);
    #2 rst_ni = 1'b0;
    #1;
    chk("mem_req_async_drop", 64'(dmem_req_o), 64'd0);
    chk("imem_req_in_rst",    64'(imem_req_o), 64'd0);
    chk("instret_async_clr",  64'(instret_o),  64'd0);
    @(negedge clk);
    @(negedge clk);
    rst_ni = 1'b1;
    #1;
    chk("restart_req",  64'(imem_req_o),  64'd1);
    chk("restart_addr", 64'(imem_addr_o), 64'h80);
    step(32'h00500093, 0, 0, 32'h0, nxt, cpi, ill, dreq, daddr, dwe, wdata, dsize, dst);
    chk("restart_next_pc", 64'(nxt), 64'h84);
    chk("restart_instret", 64'(instret_o), 64'd1);
    chk("restart_x1", 64'(dut.u_rf.rf_mem[1]), 64'd5);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/riscv_core_mc.md
# riscv_core_mc

Multi-cycle, parametrised successor of the single-cycle RV32I core. It fetches and executes over several cycles through a state machine. Instruction and data memories use request/valid handshakes instead of a global stall, so variable-latency memories attach directly. Adds a configurable reset vector, illegal-instruction trapping and a retired-instruction counter; reuses the existing `rf_riscv`, `alu_riscv` and `decoder_riscv`.

## Interface
Parameters:
- `RESET_ADDR`, default 32'h0000_0000: PC value after reset.
- `TRAP_ADDR`, default 32'h0000_0100: PC loaded on an illegal instruction.
- `CNT_W`, default 32: width of the retired-instruction counter (legal range 1..64).

Ports:
- `clk_i` in 1: single clock, rising edge.
- `rst_ni` in 1: reset, asynchronous assert, active-low.
- `imem_req_o` out 1: instruction fetch request, one-cycle pulse.
- `imem_addr_o` out 32: fetch address (current PC).
- `imem_rvalid_i` in 1: fetched instruction valid.
- `imem_rdata_i` in 32: fetched instruction.
- `dmem_req_o` out 1: data request, held until accepted.
- `dmem_we_o` out 1: 1 = store.
- `dmem_size_o` out 3: funct3 size/sign code from the decoder.
- `dmem_addr_o` out 32: ALU result.
- `dmem_wdata_o` out 32: rs2 value.
- `dmem_ready_i` in 1: data access complete; load data is valid in the same cycle.
- `dmem_rdata_i` in 32: load data, already extended by the memory.
- `illegal_o` out 1: one-cycle pulse on an illegal instruction.
- `instret_o` out CNT_W: retired-instruction count.

## Operation
States: FETCH, WAIT_I, EXEC, MEM.
- **FETCH:** `imem_req_o`=1 with `imem_addr_o`=PC, then go to WAIT_I unconditionally.
- **WAIT_I:** wait for `imem_rvalid_i`. When it arrives, latch `imem_rdata_i` into the IR and go to EXEC. `imem_rvalid_i` is ignored in every other state.
- **EXEC:** decoder and ALU operate on the IR.
  - Illegal instruction: no GPR write, PC←TRAP_ADDR, `illegal_o` pulses, go to FETCH. The instruction does not count as retired.
  - Load or store: go to MEM.
  - Otherwise: write rd with the ALU result (JAL/JALR write PC+4), PC←next_pc, instret+1, go to FETCH.
- **MEM:** `dmem_req_o`=1 and all dmem outputs held stable until `dmem_ready_i`. In the ready cycle:
  - a load writes rd←`dmem_rdata_i`;
  - PC←next_pc, instret+1, go to FETCH.
- **next_pc:**
  - JALR: (rs1+imm_I) with bit 0 cleared.
  - JAL: PC+imm_J.
  - Branch taken (ALU flag): PC+imm_B.
  - Otherwise: PC+4.
- Writes to x0 are discarded by the register file.
- The GPR write enable is asserted only in the single retiring cycle.
- Arithmetic is mod 2^32. PC and instret wrap silently; instret wraps at 2^CNT_W.
- Operand muxes: a_sel and b_sel encodings are unchanged from the single-cycle core. Unused encodings select 0 for operand a and 4 for operand b.

## Timing
- Reset values: PC=RESET_ADDR, state=FETCH, IR=32'h0000_0013 (NOP), instret=0, all req/we/illegal outputs 0.
- First `imem_req_o` occurs in the first cycle after `rst_ni` deasserts.
- Reset asserted mid-operation: all state clears asynchronously and any outstanding dmem or imem transaction is abandoned. Memories must drop it.
- `imem_rvalid_i` is sampled at the earliest one cycle after the request.
- Minimum CPI:
  - ALU, branch or jump: 3 (FETCH, WAIT_I with rvalid, EXEC).
  - Load or store: 4 (adds one MEM cycle with ready asserted).
- `dmem_ready_i` asserted in the same cycle MEM is entered is legal and completes the access in that cycle.
- `illegal_o` and the instret increment never occur in the same cycle.

## Structure
- Package `riscv_core_mc_pkg` holds:
  - the state enum;
  - a_sel and b_sel encodings;
  - the NOP constant.
- Opcode constants stay in the existing decoder package.
- One new sub-module, `riscv_next_pc`: combinational next-PC and trap selection.
- Existing `rf_riscv`, `alu_riscv` and `decoder_riscv` are instantiated unchanged.

## Test plan
- **Reset:** RESET_ADDR=32'h80, release `rst_ni` → `imem_req_o`=1 with `imem_addr_o`=32'h80 on the next cycle; instret=0.
- **ALU instruction:** `addi x1,x0,5` with rvalid one cycle after req → x1=5 after 3 cycles; next fetch at PC+4; instret=1.
- **Load with wait states:** `lw x2,0(x1)` with `dmem_ready_i` after 3 wait cycles and `dmem_rdata_i`=32'hDEAD_BEEF → `dmem_req_o` held for 4 cycles with addr=5; x2=32'hDEAD_BEEF; instret+1.
- **Branch and jump:**
  - `beq x0,x0,-8` at 32'h40 → next fetch at 32'h38.
  - `jalr x1,4(x3)` with x3=32'h101 → PC=32'h104 and x1=old PC+4.
- **Illegal instruction:** IR=32'h0000_0000 → `illegal_o` pulses once; next fetch at TRAP_ADDR; no GPR write; instret unchanged.
- **Reset during MEM:** assert `rst_ni`=0 while `dmem_req_o`=1 → `dmem_req_o` drops immediately (asynchronously); after release, fetch restarts at RESET_ADDR with instret=0.
